// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard-unit controls, branch feedback, imem port, IF/ID outputs.
interface fetch_if #(
  parameter int unsigned ADDR_W = 9
) ();

  logic              le_pc;
  logic              le_ifid;
  logic              redirect;
  logic              nullify;
  logic [31:0]       target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_pc;
  logic [31:0]       if_id_npc;
  logic              if_id_valid;
  logic [31:0]       fetch_count;

  // Environment side: hazard unit, branch resolution and instruction memory
  modport master (
    output le_pc, le_ifid, redirect, nullify, target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc, if_id_npc, if_id_valid, fetch_count
  );

  // Fetch unit side
  modport slave (
    input  le_pc, le_ifid, redirect, nullify, target, imem_data,
    output imem_addr, if_id_instr, if_id_pc, if_id_npc, if_id_valid, fetch_count
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/nPC, imem addressing, IF/ID register and fetch counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 9,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic   clk,
  input logic   reset,
  fetch_if.slave bus
);

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] CNT_MAX  = '1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [0:0] {WARM, RUN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [XLEN-1:0] inpc_q, inpc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            valid_load;
  logic [XLEN-1:0] tgt_al;

  assign tgt_al = bus.target & ALIGN_MASK;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WARM;
    else       state_q <= state_d;
  end

  // Next-state, PC and IF/ID selection; redirect beats stall beats advance
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    inpc_d     = inpc_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    valid_load = 1'b0;

    case (state_q)
      WARM: begin
        state_d = RUN;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
      RUN: begin
        if (bus.redirect) begin
          // Delay slot is the word at the current PC
          pc_d   = tgt_al;
          npc_d  = tgt_al + PC_STEP;
          ipc_d  = pc_q;
          inpc_d = npc_q;
          if (bus.nullify) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end else begin
            instr_d    = bus.imem_data;
            valid_d    = 1'b1;
            valid_load = 1'b1;
          end
        end else begin
          if (bus.le_ifid) begin
            if (bus.le_pc) begin
              instr_d    = bus.imem_data;
              ipc_d      = pc_q;
              inpc_d     = npc_q;
              valid_d    = 1'b1;
              valid_load = 1'b1;
            end else begin
              // Bubble: the held PC word will be fetched again once the stall clears
              instr_d = NOP_WORD;
              valid_d = 1'b0;
            end
          end
          if (bus.le_pc) begin
            pc_d  = npc_q;
            npc_d = npc_q + PC_STEP;
          end
        end
      end
      default: state_d = WARM;
    endcase

    if (valid_load && (cnt_q != CNT_MAX)) cnt_d = cnt_q + XLEN'(1);
  end

  // PC, IF/ID and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + PC_STEP;
      instr_q <= NOP_WORD;
      ipc_q   <= '0;
      inpc_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      inpc_q  <= inpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q[ADDR_W-1:0];
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ipc_q;
  assign bus.if_id_npc   = inpc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register.
- Produces the 32-bit instruction word consumed by the control unit.
- Consumes the branch/unconditional-branch outcome fed back from later stages.
- Owns PC/nPC, drives the instruction-memory address, and squashes or holds the IF/ID word on redirect or stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 9, instruction-memory address width in bytes; imem_addr = PC[ADDR_W-1:0].
- NOP_WORD, 32'h0000_0000, word injected into IF/ID on squash or bubble.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- le_pc  in  1  PC/nPC load enable from the hazard unit; 0 = stall fetch.
- le_ifid  in  1  IF/ID load enable from the hazard unit; 0 = hold IF/ID.
- redirect  in  1  taken branch: (B AND condition true) OR UB, resolved downstream.
- nullify  in  1  with redirect, squash the delay-slot instruction.
- target  in  32  branch target byte address.
- imem_addr  out  ADDR_W  combinational copy of PC[ADDR_W-1:0].
- imem_data  in  32  combinational instruction-memory read data at imem_addr.
- if_id_instr  out  32  instruction presented to the control unit.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_npc  out  32  PC+4 of if_id_instr, used as link value.
- if_id_valid  out  1  1 = if_id_instr is a real fetched word.
- fetch_count  out  32  count of valid words loaded into IF/ID; saturates at 32'hFFFF_FFFF.

Behaviour:
Reset (asynchronous, any time, including mid-redirect):
- PC=RESET_PC, nPC=RESET_PC+4.
- if_id_instr=NOP_WORD, if_id_pc=0, if_id_npc=0, if_id_valid=0, fetch_count=0.
- state=WARM.

FSM states:
- WARM: one cycle after reset release. PC/nPC hold; IF/ID loads NOP_WORD with valid=0; next state RUN. le_pc, le_ifid and redirect are ignored in WARM.
- RUN: normal operation; stays in RUN until reset.

PC update in RUN (priority redirect > stall > advance):
- redirect=1: PC<=target, nPC<=target+4. Redirect overrides le_pc=0.
- redirect=0, le_pc=0: PC/nPC hold.
- otherwise: PC<=nPC, nPC<=nPC+4.

IF/ID update in RUN (delay slot = word at current PC when redirect is seen):
- redirect=1, nullify=0: load imem_data, PC, nPC; valid=1. Overrides le_ifid=0.
- redirect=1, nullify=1: load NOP_WORD; valid=0; if_id_pc/npc still load PC/nPC.
- redirect=0, le_ifid=0: hold all IF/ID fields.
- redirect=0, le_ifid=1, le_pc=0: load NOP_WORD, valid=0. This bubble must never duplicate the held word.
- redirect=0, le_ifid=1, le_pc=1: load imem_data, PC, nPC; valid=1.

Counter and arithmetic:
- fetch_count increments on every edge where IF/ID loads with valid=1; saturates, no wrap.
- PC arithmetic is 32-bit modulo 2^32: nPC at 32'hFFFF_FFFC wraps to 0.
- target[1:0] is forced to 2'b00 when loaded into PC.

Latency:
- imem_data to if_id_instr: 1 cycle.
- Redirect to first target word in IF/ID: 2 edges (edge 1 loads PC, edge 2 loads IF/ID).

Outputs:
- All outputs are registered except imem_addr.
- No X propagation from imem_data while valid=0.

Test Plan:
- Reset release, le_pc=le_ifid=1, imem holds words W0..W3 at 0,4,8,12 -> edge 1 valid=0 (WARM); edges 2..5 show W0..W3 with if_id_pc 0,4,8,12 and if_id_npc 4,8,12,16; fetch_count=4.
- In RUN at PC=8: le_pc=0, le_ifid=0 for 2 cycles, then le_pc=0, le_ifid=1 for 1 cycle -> IF/ID held 2 cycles, then NOP with valid=0; PC stays 8; fetch_count unchanged.
- At PC=12: redirect=1, nullify=0, target=0x40 -> IF/ID = word@12 valid=1; next edge IF/ID = word@0x40, if_id_pc=0x40, if_id_npc=0x44.
- Same case with nullify=1 -> IF/ID = NOP_WORD, valid=0, if_id_pc=12; next word is from 0x40; fetch_count does not count the squashed slot.
- Redirect with le_pc=0 and le_ifid=0, target=0x83 -> PC=0x80 (redirect wins, low bits cleared); IF/ID loads delay slot.
- Assert reset asynchronously mid-cycle during a redirect -> all outputs return to reset values before the next edge; one WARM cycle follows release.
- Preload fetch_count=32'hFFFF_FFFE via forced state, fetch 3 valid words -> count holds at 32'hFFFF_FFFF.
